// File: rtl/xy_scan.sv
// xy_scan: oscilloscope Pong display stage.
// Snapshots ball, paddle and score once per frame, then emits a blanked,
// dwell-timed X/Y point stream: ball raster, paddle line, two 7-segment digits.
module xy_scan #(
  parameter int unsigned X_MAX           = 255,
  parameter int unsigned Y_MAX           = 220,
  parameter int unsigned PLATE_HALFWIDTH = 15,
  parameter int unsigned DWELL           = 4,
  parameter int unsigned SETTLE          = 2,
  parameter int unsigned DIG_X0          = 8,
  parameter int unsigned DIG_Y0          = 230
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] x_b,
  input  logic [7:0] y_b,
  input  logic [7:0] y_p_mid,
  input  logic [7:0] score,
  output logic [7:0] dac_x,
  output logic [7:0] dac_y,
  output logic       blank,
  output logic       frame_start
);

  localparam int unsigned W = 8;

  typedef enum logic [2:0] {
    S_START, S_LATCH, S_DIV, S_BALL, S_PADDLE, S_TENS, S_UNITS
  } state_t;

  state_t r_state, w_next;

  logic [W-1:0] r_xb, r_yb, r_ymin, r_ymax, r_rem;
  logic [3:0]   r_tens;
  logic [W-1:0] r_pt, r_cnt;
  logic [2:0]   r_seg;
  logic [W-1:0] r_dac_x, r_dac_y;
  logic         r_blank, r_fs;

  logic [W-1:0] w_ymin, w_ymax, w_score_sat;
  logic [W-1:0] w_plen, w_npts, w_x0, w_i, w_x, w_y;
  logic [3:0]   w_dval;
  logic [6:0]   w_mask;
  logic [1:0]   w_bdx, w_bdy;
  logic         w_digit, w_lit, w_in_stroke, w_first, w_settle;
  logic         w_pt_end, w_stroke_end, w_seg_done;

  // Segment pattern, bit 0 = a .. bit 6 = g
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // base + d - 1, clamped to the 8-bit DAC range
  function automatic logic [W-1:0] sat_off(input logic [W-1:0] base, input logic [1:0] d);
    logic [W+1:0] s;
    s = {2'b00, base} + (W+2)'(d);
    if (s == '0)                 sat_off = '0;
    else if (s > (W+2)'(256))    sat_off = '1;
    else                         sat_off = W'(s - (W+2)'(1));
  endfunction

  // Paddle extent and saturated score from the live inputs, used at capture
  always_comb begin
    w_ymin      = (y_p_mid >= W'(PLATE_HALFWIDTH)) ? y_p_mid - W'(PLATE_HALFWIDTH) : '0;
    w_ymax      = (y_p_mid <= W'(Y_MAX - PLATE_HALFWIDTH)) ? y_p_mid + W'(PLATE_HALFWIDTH)
                                                           : W'(Y_MAX);
    w_score_sat = (score > W'(99)) ? W'(99) : score;
  end

  // Stroke/point sequencing decode
  always_comb begin
    w_digit = (r_state == S_TENS) || (r_state == S_UNITS);
    w_dval  = (r_state == S_TENS) ? r_tens : r_rem[3:0];
    w_mask  = seg7(w_dval);
    if ((r_state == S_TENS) && (r_tens == 4'd0)) w_mask = '0;
    w_lit       = w_mask[r_seg];
    w_in_stroke = (r_state == S_BALL) || (r_state == S_PADDLE) || (w_digit && w_lit);
    w_first     = (r_pt == '0);
    w_plen      = w_first ? W'(SETTLE + DWELL) : W'(DWELL);
    w_settle    = w_first && (r_cnt < W'(SETTLE));
    case (r_state)
      S_BALL:   w_npts = W'(9);
      S_PADDLE: w_npts = W'(r_ymax - r_ymin + W'(1));
      default:  w_npts = W'(8);
    endcase
    w_pt_end     = w_in_stroke && (r_cnt == w_plen - W'(1));
    w_stroke_end = w_pt_end && (r_pt == w_npts - W'(1));
    w_seg_done   = w_digit && (!w_lit || w_stroke_end);
  end

  // Coordinate of the current point
  always_comb begin
    w_bdy = (r_pt >= W'(6)) ? 2'd2 : ((r_pt >= W'(3)) ? 2'd1 : 2'd0);
    w_bdx = 2'(r_pt - W'(3) * W'(w_bdy));
    w_x0  = (r_state == S_TENS) ? W'(DIG_X0) : W'(DIG_X0 + 12);
    w_i   = W'(r_pt[2:0]);
    w_x   = r_dac_x;
    w_y   = r_dac_y;
    case (r_state)
      S_BALL: begin
        w_x = sat_off(r_xb, w_bdx);
        w_y = sat_off(r_yb, w_bdy);
      end
      S_PADDLE: begin
        w_x = W'(X_MAX);
        w_y = r_ymin + r_pt;
      end
      S_TENS, S_UNITS: begin
        case (r_seg)
          3'd0: begin w_x = w_x0 + w_i;       w_y = W'(DIG_Y0 + 16);       end
          3'd1: begin w_x = w_x0 + W'(8);     w_y = W'(DIG_Y0 + 16) - w_i; end
          3'd2: begin w_x = w_x0 + W'(8);     w_y = W'(DIG_Y0 + 8) - w_i;  end
          3'd3: begin w_x = w_x0 + W'(8) - w_i; w_y = W'(DIG_Y0);          end
          3'd4: begin w_x = w_x0;             w_y = W'(DIG_Y0) + w_i;      end
          3'd5: begin w_x = w_x0;             w_y = W'(DIG_Y0 + 8) + w_i;  end
          default: begin w_x = w_x0 + w_i;    w_y = W'(DIG_Y0 + 8);        end
        endcase
      end
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_START:  w_next = S_LATCH;
      S_LATCH:  w_next = S_DIV;
      S_DIV:    if (r_rem < W'(10)) w_next = S_BALL;
      S_BALL:   if (w_stroke_end) w_next = S_PADDLE;
      S_PADDLE: if (w_stroke_end) w_next = S_TENS;
      S_TENS:   if (w_seg_done && (r_seg == 3'd6)) w_next = S_UNITS;
      S_UNITS:  if (w_seg_done && (r_seg == 3'd6)) w_next = S_START;
      default:  w_next = S_START;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_START;
    else       r_state <= w_next;
  end

  // Frame snapshot, decimal conversion and point/segment counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_xb   <= '0;
      r_yb   <= '0;
      r_ymin <= '0;
      r_ymax <= '0;
      r_rem  <= '0;
      r_tens <= '0;
      r_pt   <= '0;
      r_cnt  <= '0;
      r_seg  <= '0;
    end else begin
      if (w_in_stroke && !w_pt_end) begin
        r_cnt <= r_cnt + W'(1);
      end else if (w_in_stroke && !w_stroke_end) begin
        r_cnt <= '0;
        r_pt  <= r_pt + W'(1);
      end else begin
        r_cnt <= '0;
        r_pt  <= '0;
      end
      if (w_seg_done) r_seg <= (r_seg == 3'd6) ? 3'd0 : r_seg + 3'd1;
      if (r_state == S_LATCH) begin
        r_xb   <= x_b;
        r_yb   <= y_b;
        r_ymin <= w_ymin;
        r_ymax <= w_ymax;
        r_rem  <= w_score_sat;
        r_tens <= '0;
      end else if ((r_state == S_DIV) && (r_rem >= W'(10))) begin
        r_rem  <= r_rem - W'(10);
        r_tens <= r_tens + 4'd1;
      end
    end
  end

  // Registered DAC, blank and frame pulse; DAC holds while no stroke is active
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dac_x <= '0;
      r_dac_y <= '0;
      r_blank <= 1'b1;
      r_fs    <= 1'b0;
    end else begin
      r_fs    <= (r_state == S_LATCH);
      r_blank <= !w_in_stroke || w_settle;
      if (w_in_stroke) begin
        r_dac_x <= w_x;
        r_dac_y <= w_y;
      end
    end
  end

  assign dac_x       = r_dac_x;
  assign dac_y       = r_dac_y;
  assign blank       = r_blank;
  assign frame_start = r_fs;

endmodule

// File: doc/xy_scan.md
# xy_scan

Downstream display stage for the oscilloscope Pong game. It consumes the game controller's ball position, paddle centre and score, plus the player's paddle input. It turns them into a time-multiplexed point stream for the X/Y DACs driving the oscilloscope, drawing in order: ball, paddle, two-digit score. Inputs are snapshotted once per frame so every frame is self-consistent.

## Interface
- X_MAX, 255: right border; paddle column.
- Y_MAX, 220: playfield top.
- PLATE_HALFWIDTH, 15: paddle half-length.
- DWELL, 4: cycles each point is held.
- SETTLE, 2: blanked cycles before the first point of each stroke.
- DIG_X0, 8: tens-digit origin X; units digit at DIG_X0+12.
- DIG_Y0, 230: digit origin Y (bottom-left).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- x_b  in  8  ball X.
- y_b  in  8  ball Y.
- y_p_mid  in  8  paddle centre Y.
- score  in  8  binary score.
- dac_x  out  8  X DAC code, registered.
- dac_y  out  8  Y DAC code, registered.
- blank  out  1  beam blank, 1 = beam off; registered.
- frame_start  out  1  one-cycle pulse on the input-capture cycle.

## Operation
- FSM cycle: START → LATCH → DIV → BALL → PADDLE → TENS → UNITS → START, repeating indefinitely.
- START: 1 cycle, blank=1.
- LATCH: 1 cycle. Captures x_b, y_b, y_p_mid. Captures score saturated to 99. frame_start=1 only here. blank=1.
- DIV: iterative binary-to-decimal conversion, blank=1.
  - Each cycle, if remainder ≥10, subtract 10 and increment tens.
  - The cycle with remainder <10 exits to BALL and counts as a DIV cycle.
  - DIV lasts tens+1 cycles.
- BALL: one stroke of 9 points, a 3×3 raster.
  - X from x_b−1 to x_b+1, outer loop Y from y_b−1 to y_b+1.
  - Coordinates saturate at 0 and 255; duplicated points are still drawn.
- PADDLE: one stroke at dac_x=X_MAX, dac_y stepping +1 from y_p_min to y_p_max inclusive.
  - y_p_min = y_p_mid≥PLATE_HALFWIDTH ? y_p_mid−PLATE_HALFWIDTH : 0.
  - y_p_max = y_p_mid≤Y_MAX−PLATE_HALFWIDTH ? y_p_mid+PLATE_HALFWIDTH : Y_MAX.
- TENS / UNITS: seven segments, processed in order a..g, each with i=0..7 and origin (x0,y0). Each lit segment is its own stroke of 8 points:
  - a (x0+i, y0+16)
  - b (x0+8, y0+16−i)
  - c (x0+8, y0+8−i)
  - d (x0+8−i, y0)
  - e (x0, y0+i)
  - f (x0, y0+8+i)
  - g (x0+i, y0+8)
- Segment patterns: standard 7-segment (0 = a–f; 1 = b,c; 7 = a,b,c; 8 = all; etc.).
- Unlit segment: consumes exactly 1 cycle. blank=1, dac_x/dac_y hold their previous values.
- Tens digit is fully unlit (7 skip cycles) when score<10.
- Mid-frame input changes are ignored until the next LATCH.

## Timing
- Stroke: first point SETTLE cycles with blank=1, then DWELL cycles with blank=0. Each later point is DWELL cycles, blank=0.
- dac_x/dac_y change only on the edge starting a new point, including the blanked settle window.
- Frame length = 2 + (tens+1) + (SETTLE+9·DWELL) + (SETTLE+n_pad·DWELL) + Σ digit cycles.
  - n_pad = y_p_max−y_p_min+1.
  - Each lit segment costs SETTLE+8·DWELL; each unlit segment costs 1.
- Reset (asynchronous, any time, mid-stroke included):
  - dac_x=0, dac_y=0, blank=1, frame_start=0.
  - FSM enters START and all counters clear.
  - First frame_start occurs 1 cycle after reset release, i.e. on the second post-release edge.
- blank is never 0 outside BALL, PADDLE, TENS, UNITS.

## Test plan
- Reset release; x_b=127, y_b=110, y_p_mid=100, score=0:
  - frame_start at cycle 1, then period 379 cycles.
  - Ball points (126..128, 109..111).
  - Paddle y 85..115 at x=255.
  - Tens fully blanked; units draws segments a–f.
- y_p_mid=5 then y_p_mid=215:
  - Paddle spans 0..20 then 200..220.
  - 21 points each.
- x_b=0, y_b=0:
  - Ball raster includes saturated coordinates (0,0); 9 points, 36 unblanked cycles.
- score=57 → DIV lasts 6 cycles, digits 5 (a,c,d,f,g) and 7 (a,b,c).
- score=200 → displayed 99, DIV lasts 10 cycles.
- Change all inputs mid-PADDLE:
  - Current frame unchanged.
  - New values drawn only after the next frame_start.
- Assert reset mid-stroke:
  - Outputs go to reset values immediately, without waiting for a clock edge.
  - Clean restart follows.
